// File: rtl/acc_flag_unit.sv
// acc_flag_unit: 8-bit accumulator with Z/N/C flags and a rotate-through-carry run one bit per clock.
// Load lands one edge after sampling; rotates take cnt cycles plus a done pulse; ACC_SHADOW_EN adds a save/restore shadow.
module acc_flag_unit (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [7:0] alu_in,
   input  logic       c_in,
   input  logic       load,
   input  logic       shift_go,
   input  logic       shift_dir,
   input  logic [2:0] shift_cnt,
   input  logic       save,
   input  logic       restore,
   output logic [7:0] acc,
   output logic       flag_z,
   output logic       flag_n,
   output logic       flag_c,
   output logic       busy,
   output logic       done
);
   typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

   state_t     state, state_nx;
   logic [7:0] acc_r, acc_nx;
   logic       c_r, c_nx;
   logic       dir_r, dir_nx;
   logic [2:0] cnt_r, cnt_nx;
   logic       restore_en;
   logic [8:0] shadow_val;

`ifdef ACC_SHADOW_EN
   logic [8:0] shadow_r, shadow_nx;

   assign restore_en = restore;
   assign shadow_val = shadow_r;

   // save works off the pre-edge value, so save+restore swaps and save+load keeps the old value
   always_comb begin
      shadow_nx = shadow_r;
      if (state == IDLE && save)
         shadow_nx = {c_r, acc_r};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         shadow_r <= 9'h000;
      else
         shadow_r <= shadow_nx;
   end
`else
   logic unused_shadow_ports;

   assign unused_shadow_ports = save ^ restore;
   assign restore_en          = 1'b0;
   assign shadow_val          = 9'h000;
`endif

   always_comb begin
      state_nx = state;
      acc_nx   = acc_r;
      c_nx     = c_r;
      dir_nx   = dir_r;
      cnt_nx   = cnt_r;
      case (state)
         IDLE: begin
            if (restore_en) begin
               {c_nx, acc_nx} = shadow_val;
            end else if (load) begin
               acc_nx = alu_in;
               c_nx   = c_in;
            end else if (shift_go) begin
               dir_nx   = shift_dir;
               cnt_nx   = shift_cnt;
               state_nx = (shift_cnt != 3'd0) ? SHIFT : DONE;
            end
         end
         SHIFT: begin
            // 9-bit rotate through carry
            if (dir_r)
               {acc_nx, c_nx} = {c_r, acc_r};
            else
               {c_nx, acc_nx} = {acc_r, c_r};
            cnt_nx = cnt_r - 3'd1;
            if (cnt_r == 3'd1)
               state_nx = DONE;
         end
         DONE:    state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         acc_r <= 8'h00;
         c_r   <= 1'b0;
         dir_r <= 1'b0;
         cnt_r <= 3'd0;
      end else begin
         state <= state_nx;
         acc_r <= acc_nx;
         c_r   <= c_nx;
         dir_r <= dir_nx;
         cnt_r <= cnt_nx;
      end
   end

   assign acc    = acc_r;
   assign flag_c = c_r;
   assign flag_z = (acc_r == 8'h00);
   assign flag_n = acc_r[7];
   assign busy   = (state == SHIFT);
   assign done   = (state == DONE);
endmodule

// File: tb/tb_acc_flag_unit.sv
// Directed bench for acc_flag_unit; shadow checks follow ACC_SHADOW_EN.
module tb_acc_flag_unit;
   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [7:0] alu_in = 8'h00;
   logic       c_in = 1'b0;
   logic       load = 1'b0;
   logic       shift_go = 1'b0;
   logic       shift_dir = 1'b0;
   logic [2:0] shift_cnt = 3'd0;
   logic       save = 1'b0;
   logic       restore = 1'b0;
   logic [7:0] acc;
   logic       flag_z, flag_n, flag_c, busy, done;

   int n_checks = 0;
   int n_fail   = 0;

   acc_flag_unit dut (
      .clk(clk), .rst_n(rst_n), .alu_in(alu_in), .c_in(c_in), .load(load),
      .shift_go(shift_go), .shift_dir(shift_dir), .shift_cnt(shift_cnt),
      .save(save), .restore(restore), .acc(acc), .flag_z(flag_z),
      .flag_n(flag_n), .flag_c(flag_c), .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_load(input logic [7:0] v, input logic c);
      alu_in = v;
      c_in   = c;
      load   = 1'b1;
      step();
      load   = 1'b0;
   endtask

   task automatic start_shift(input logic dir, input logic [2:0] cnt);
      shift_dir = dir;
      shift_cnt = cnt;
      shift_go  = 1'b1;
      step();
      shift_go  = 1'b0;
   endtask

   task automatic test_reset();
      step();
      n_checks++;
      if ({acc, flag_z, flag_n, flag_c, busy, done} !== {8'h00, 5'b10000}) begin
         n_fail++;
         $display("FAIL reset_state: got acc=%h z/n/c/busy/done=%b required acc=00 10000", acc, {flag_z, flag_n, flag_c, busy, done});
      end
      rst_n = 1'b1;
      step();
      do_load(8'h3C, 1'b1);
      n_checks++;
      if (acc !== 8'h3C) begin
         n_fail++;
         $display("FAIL reset_preload: got acc=%h required 3c", acc);
      end
      #3 rst_n = 1'b0;
      #1;
      n_checks++;
      if ({acc, flag_z, flag_n, flag_c, busy, done} !== {8'h00, 5'b10000}) begin
         n_fail++;
         $display("FAIL reset_async: got acc=%h z/n/c/busy/done=%b required acc=00 10000", acc, {flag_z, flag_n, flag_c, busy, done});
      end
      @(negedge clk) rst_n = 1'b1;
      step();
   endtask

   task automatic test_load();
      do_load(8'h80, 1'b1);
      n_checks++;
      if ({acc, flag_n, flag_z, flag_c} !== {8'h80, 3'b101}) begin
         n_fail++;
         $display("FAIL load_80: got acc=%h n/z/c=%b required acc=80 101", acc, {flag_n, flag_z, flag_c});
      end
   endtask

   task automatic test_left_rotate();
      logic [7:0] exp_acc [3] = '{8'h02, 8'h05, 8'h0A};
      logic       exp_c   [3] = '{1'b1, 1'b0, 1'b0};
      logic       exp_bsy [3] = '{1'b1, 1'b1, 1'b0};
      logic       exp_dn  [3] = '{1'b0, 1'b0, 1'b1};
      do_load(8'h81, 1'b0);
      start_shift(1'b0, 3'd3);
      n_checks++;
      if ({acc, busy, done} !== {8'h81, 2'b10}) begin
         n_fail++;
         $display("FAIL left_start: got acc=%h busy/done=%b required acc=81 10", acc, {busy, done});
      end
      alu_in = 8'hFF;
      c_in   = 1'b1;
      load   = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         load = 1'b0;
         n_checks++;
         if ({acc, flag_c, busy, done} !== {exp_acc[i], exp_c[i], exp_bsy[i], exp_dn[i]}) begin
            n_fail++;
            $display("FAIL left_step%0d: got acc=%h c/busy/done=%b required acc=%h %b", i, acc, {flag_c, busy, done}, exp_acc[i], {exp_c[i], exp_bsy[i], exp_dn[i]});
         end
      end
      step();
      n_checks++;
      if ({acc, busy, done} !== {8'h0A, 2'b00}) begin
         n_fail++;
         $display("FAIL left_after_done: got acc=%h busy/done=%b required acc=0a 00", acc, {busy, done});
      end
   endtask

   task automatic test_right_rotate_cnt0();
      do_load(8'h01, 1'b0);
      start_shift(1'b1, 3'd1);
      n_checks++;
      if ({acc, busy, done} !== {8'h01, 2'b10}) begin
         n_fail++;
         $display("FAIL right_start: got acc=%h busy/done=%b required acc=01 10", acc, {busy, done});
      end
      step();
      n_checks++;
      if ({acc, flag_c, flag_z, busy, done} !== {8'h00, 4'b1101}) begin
         n_fail++;
         $display("FAIL right_step: got acc=%h c/z/busy/done=%b required acc=00 1101", acc, {flag_c, flag_z, busy, done});
      end
      step();
      start_shift(1'b1, 3'd0);
      n_checks++;
      if ({acc, flag_c, busy, done} !== {8'h00, 3'b101}) begin
         n_fail++;
         $display("FAIL cnt0_done: got acc=%h c/busy/done=%b required acc=00 101", acc, {flag_c, busy, done});
      end
      // shift_go held through DONE is ignored there, then accepted back in IDLE
      shift_go = 1'b1;
      step();
      n_checks++;
      if ({busy, done} !== 2'b00) begin
         n_fail++;
         $display("FAIL go_during_done: got busy/done=%b required 00", {busy, done});
      end
      step();
      shift_go = 1'b0;
      n_checks++;
      if ({acc, busy, done} !== {8'h00, 2'b01}) begin
         n_fail++;
         $display("FAIL go_after_done: got acc=%h busy/done=%b required acc=00 01", acc, {busy, done});
      end
      step();
   endtask

   task automatic test_priority();
      do_load(8'h0F, 1'b0);
      alu_in    = 8'hF0;
      c_in      = 1'b1;
      load      = 1'b1;
      shift_go  = 1'b1;
      shift_dir = 1'b0;
      shift_cnt = 3'd3;
      step();
      load     = 1'b0;
      shift_go = 1'b0;
      n_checks++;
      if ({acc, flag_c, flag_n, busy, done} !== {8'hF0, 4'b1100}) begin
         n_fail++;
         $display("FAIL load_over_go: got acc=%h c/n/busy/done=%b required acc=f0 1100", acc, {flag_c, flag_n, busy, done});
      end
      step();
      n_checks++;
      if ({acc, busy, done} !== {8'hF0, 2'b00}) begin
         n_fail++;
         $display("FAIL go_dropped: got acc=%h busy/done=%b required acc=f0 00", acc, {busy, done});
      end
   endtask

   task automatic test_abort();
      logic seen_done = 1'b0;
      do_load(8'h55, 1'b0);
      start_shift(1'b0, 3'd7);
      step();
      n_checks++;
      if ({acc, busy} !== {8'hAA, 1'b1}) begin
         n_fail++;
         $display("FAIL abort_mid: got acc=%h busy=%b required acc=aa 1", acc, busy);
      end
      #2 rst_n = 1'b0;
      #1;
      n_checks++;
      if ({acc, busy, done, flag_z} !== {8'h00, 3'b001}) begin
         n_fail++;
         $display("FAIL abort_reset: got acc=%h busy/done/z=%b required acc=00 001", acc, {busy, done, flag_z});
      end
      @(negedge clk) rst_n = 1'b1;
      for (int i = 0; i < 10; i++) begin
         step();
         if (done || busy) seen_done = 1'b1;
      end
      n_checks++;
      if (seen_done !== 1'b0) begin
         n_fail++;
         $display("FAIL abort_no_done: got busy/done activity=%b required 0", seen_done);
      end
   endtask

   task automatic test_shadow();
`ifdef ACC_SHADOW_EN
      do_load(8'h5A, 1'b0);
      save = 1'b1;
      step();
      save = 1'b0;
      do_load(8'h33, 1'b1);
      alu_in  = 8'h77;
      load    = 1'b1;
      restore = 1'b1;
      step();
      load    = 1'b0;
      restore = 1'b0;
      n_checks++;
      if ({acc, flag_c} !== {8'h5A, 1'b0}) begin
         n_fail++;
         $display("FAIL shadow_restore: got acc=%h c=%b required acc=5a 0", acc, flag_c);
      end
      do_load(8'h33, 1'b1);
      save    = 1'b1;
      restore = 1'b1;
      step();
      save    = 1'b0;
      restore = 1'b0;
      n_checks++;
      if ({acc, flag_c} !== {8'h5A, 1'b0}) begin
         n_fail++;
         $display("FAIL shadow_swap_acc: got acc=%h c=%b required acc=5a 0", acc, flag_c);
      end
      restore = 1'b1;
      step();
      restore = 1'b0;
      n_checks++;
      if ({acc, flag_c} !== {8'h33, 1'b1}) begin
         n_fail++;
         $display("FAIL shadow_swap_shadow: got acc=%h c=%b required acc=33 1", acc, flag_c);
      end
      do_load(8'h11, 1'b0);
      alu_in = 8'h22;
      load   = 1'b1;
      save   = 1'b1;
      step();
      load   = 1'b0;
      save   = 1'b0;
      restore = 1'b1;
      step();
      restore = 1'b0;
      n_checks++;
      if ({acc, flag_c} !== {8'h11, 1'b0}) begin
         n_fail++;
         $display("FAIL shadow_save_with_load: got acc=%h c=%b required acc=11 0", acc, flag_c);
      end
`else
      do_load(8'h5A, 1'b0);
      save = 1'b1;
      step();
      save = 1'b0;
      alu_in  = 8'h77;
      c_in    = 1'b0;
      load    = 1'b1;
      restore = 1'b1;
      step();
      load = 1'b0;
      n_checks++;
      if ({acc, flag_c} !== {8'h77, 1'b0}) begin
         n_fail++;
         $display("FAIL noshadow_load_wins: got acc=%h c=%b required acc=77 0", acc, flag_c);
      end
      step();
      restore = 1'b0;
      n_checks++;
      if ({acc, flag_c} !== {8'h77, 1'b0}) begin
         n_fail++;
         $display("FAIL noshadow_restore_ignored: got acc=%h c=%b required acc=77 0", acc, flag_c);
      end
`endif
   endtask

   initial begin
      test_reset();
      test_load();
      test_left_rotate();
      test_right_rotate_cnt0();
      test_priority();
      test_abort();
      test_shadow();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
